// File: rtl/mm2s_packet_router.sv
// rtl/mm2s_packet_router.sv - packet-aware MM2S AXI Stream router to NUM_FIFOS sink FIFOs
module mm2s_packet_router #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int AXIS_DEST_WIDTH = 4,
    parameter int NUM_FIFOS       = 2,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [AXIS_DATA_WIDTH-1:0]     SRC_AXIS_tdata_in,
    input  logic [AXIS_DEST_WIDTH-1:0]     SRC_AXIS_tdest_in,
    input  logic                           SRC_AXIS_tlast_in,
    input  logic                           SRC_AXIS_tvalid_in,
    output logic                           SRC_AXIS_tready_out,
    output logic [NUM_FIFOS-1:0]           fifo_wren_out,
    input  logic [NUM_FIFOS-1:0]           fifo_full_in,
    output logic [FIFO_DATA_WIDTH*NUM_FIFOS-1:0] fifo_data_out,
    output logic [NUM_FIFOS-1:0]           fifo_last_out,
    input  logic                           clear_counters_in,
    output logic [CNT_WIDTH*NUM_FIFOS-1:0] pkt_count_out,
    output logic [CNT_WIDTH-1:0]           drop_count_out,
    output logic                           locked_out
);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    localparam logic [AXIS_DEST_WIDTH:0] NF = (AXIS_DEST_WIDTH+1)'(NUM_FIFOS);

    state_t                      state_q, state_d;
    logic [AXIS_DEST_WIDTH-1:0]  lock_q, lock_d;
    logic [CNT_WIDTH-1:0]        pkt_cnt_q [NUM_FIFOS];
    logic [CNT_WIDTH-1:0]        drop_cnt_q;

    logic                        fwd;
    logic [AXIS_DEST_WIDTH-1:0]  sel;
    logic                        tready;
    logic                        accept;
    logic [NUM_FIFOS-1:0]        wren;
    logic                        drop_inc;

    always_comb begin
        fwd      = 1'b0;
        sel      = lock_q;
        tready   = 1'b1;
        wren     = '0;
        state_d  = state_q;
        lock_d   = lock_q;
        drop_inc = 1'b0;

        if (state_q == IDLE) begin
            sel = SRC_AXIS_tdest_in;
            fwd = ({1'b0, SRC_AXIS_tdest_in} < NF);
        end else if (state_q == FWD) begin
            fwd = 1'b1;
        end

        // Only the selected FIFO's full flag can back-pressure the stream.
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (fwd && sel == AXIS_DEST_WIDTH'(i)) begin
                tready  = !fifo_full_in[i];
                wren[i] = SRC_AXIS_tvalid_in & !fifo_full_in[i];
            end
        end
        if (!rstn) begin
            tready = 1'b0;
            wren   = '0;
        end
        accept = SRC_AXIS_tvalid_in & tready;

        case (state_q)
            IDLE: if (accept) begin
                if (fwd) begin
                    if (!SRC_AXIS_tlast_in) begin
                        state_d = FWD;
                        lock_d  = SRC_AXIS_tdest_in;
                    end
                end else begin
                    drop_inc = 1'b1;
                    if (!SRC_AXIS_tlast_in) state_d = DROP;
                end
            end
            FWD:  if (accept && SRC_AXIS_tlast_in) state_d = IDLE;
            DROP: if (accept && SRC_AXIS_tlast_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign SRC_AXIS_tready_out = tready;
    assign fifo_wren_out       = wren;
    assign fifo_last_out       = wren & {NUM_FIFOS{SRC_AXIS_tlast_in}};
    assign fifo_data_out       = {NUM_FIFOS{SRC_AXIS_tdata_in[FIFO_DATA_WIDTH-1:0]}};
    assign locked_out          = (state_q == FWD) || (state_q == DROP);
    assign drop_count_out      = drop_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    // A completed packet is exactly a write carrying tlast.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt_q <= '0;
            for (int i = 0; i < NUM_FIFOS; i++) pkt_cnt_q[i] <= '0;
        end else if (clear_counters_in) begin
            drop_cnt_q <= '0;
            for (int i = 0; i < NUM_FIFOS; i++) pkt_cnt_q[i] <= '0;
        end else begin
            if (drop_inc && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
            for (int i = 0; i < NUM_FIFOS; i++) begin
                if (fifo_last_out[i] && pkt_cnt_q[i] != '1) pkt_cnt_q[i] <= pkt_cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_FIFOS; i++) pkt_count_out[i*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt_q[i];
    end

endmodule

// File: tb/tb_mm2s_packet_router.sv
// tb/tb_mm2s_packet_router.sv - scoreboard testbench for mm2s_packet_router
module tb_mm2s_packet_router;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] tdata;
    logic [3:0]  tdest;
    logic        tlast;
    logic        tvalid;
    logic        tready;
    logic [1:0]  wren;
    logic [1:0]  full;
    logic [63:0] fdata;
    logic [1:0]  flast;
    logic        clr;
    logic [31:0] pkt_count;
    logic [15:0] drop_count;
    logic        locked;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          fifo;
        logic [31:0] data;
        logic        last;
    } exp_t;
    exp_t exp_q[$];

    mm2s_packet_router dut (
        .clk                 (clk),
        .rstn                (rstn),
        .SRC_AXIS_tdata_in   (tdata),
        .SRC_AXIS_tdest_in   (tdest),
        .SRC_AXIS_tlast_in   (tlast),
        .SRC_AXIS_tvalid_in  (tvalid),
        .SRC_AXIS_tready_out (tready),
        .fifo_wren_out       (wren),
        .fifo_full_in        (full),
        .fifo_data_out       (fdata),
        .fifo_last_out       (flast),
        .clear_counters_in   (clr),
        .pkt_count_out       (pkt_count),
        .drop_count_out      (drop_count),
        .locked_out          (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && wren != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_wren", {62'd0, wren}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_wren", {62'd0, wren}, 64'd1 << e.fifo);
                check("sb_data", {32'd0, fdata[e.fifo*32 +: 32]}, {32'd0, e.data});
                check("sb_last", {62'd0, flast}, e.last ? (64'd1 << e.fifo) : 64'd0);
            end
        end
    end

    // exp_fifo < 0 means the beat must be swallowed without any write.
    task automatic send(input logic [31:0] d, input logic [3:0] dest, input logic last, input int exp_fifo);
        bit done = 0;
        tdata  = d;
        tdest  = dest;
        tlast  = last;
        tvalid = 1'b1;
        if (exp_fifo >= 0) exp_q.push_back('{exp_fifo, d, last});
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (tready) begin
                if (exp_fifo < 0) check("drop_wren", {62'd0, wren}, 64'd0);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 64'd0, 64'd1);
        tvalid = 1'b0;
    endtask

    function automatic logic [15:0] pc(input int i);
        return pkt_count[i*16 +: 16];
    endfunction

    initial begin
        rstn = 1'b0; tdata = '0; tdest = '0; tlast = 1'b0; tvalid = 1'b0; full = 2'b00; clr = 1'b0;
        #2 tvalid = 1'b1;
        #10;
        check("rst_tready", {63'd0, tready}, 64'd0);
        check("rst_wren",   {62'd0, wren},   64'd0);
        check("rst_locked", {63'd0, locked}, 64'd0);
        check("rst_pkt",    {32'd0, pkt_count}, 64'd0);
        check("rst_drop",   {48'd0, drop_count}, 64'd0);
        tvalid = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;

        // 1: tdest toggles mid-packet, packet stays on FIFO 1
        send(32'hA1, 4'd1, 1'b0, 1);
        check("t1_locked", {63'd0, locked}, 64'd1);
        send(32'hA2, 4'd0, 1'b0, 1);
        send(32'hA3, 4'd0, 1'b1, 1);
        check("t1_pkt1",   {48'd0, pc(1)}, 64'd1);
        check("t1_unlock", {63'd0, locked}, 64'd0);

        // 2: single-beat packet
        send(32'hB0, 4'd0, 1'b1, 0);
        check("t2_pkt0",   {48'd0, pc(0)}, 64'd1);
        check("t2_locked", {63'd0, locked}, 64'd0);

        // 3: invalid tdest drained, then normal routing
        send(32'hC0, 4'd5, 1'b0, -1);
        check("t3_locked", {63'd0, locked}, 64'd1);
        send(32'hC1, 4'd0, 1'b0, -1);
        send(32'hC2, 4'd1, 1'b0, -1);
        send(32'hC3, 4'd0, 1'b1, -1);
        check("t3_drop",   {48'd0, drop_count}, 64'd1);
        check("t3_locked_end", {63'd0, locked}, 64'd0);
        send(32'hD0, 4'd0, 1'b0, 0);
        send(32'hD1, 4'd0, 1'b1, 0);
        check("t3_pkt0",   {48'd0, pc(0)}, 64'd2);

        // 4: target FIFO full stalls beat 2, other FIFO full is ignored
        send(32'hE0, 4'd1, 1'b0, 1);
        full = 2'b10; tdata = 32'hE1; tdest = 4'd0; tlast = 1'b0; tvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t4_stall_tready", {63'd0, tready}, 64'd0);
            check("t4_stall_wren",   {62'd0, wren},   64'd0);
            @(posedge clk); #1 full[0] = ~full[0];
        end
        full = 2'b01;
        send(32'hE1, 4'd0, 1'b0, 1);
        send(32'hE2, 4'd0, 1'b1, 1);
        full = 2'b00;
        check("t4_pkt1", {48'd0, pc(1)}, 64'd2);

        // 5: saturation, then clear coincident with an increment
        for (int k = 0; k < 65533; k++) send(k, 4'd0, 1'b1, 0);
        check("t5_pkt0_max", {48'd0, pc(0)}, 64'hFFFF);
        send(32'hF0, 4'd0, 1'b1, 0);
        check("t5_pkt0_sat", {48'd0, pc(0)}, 64'hFFFF);
        clr = 1'b1;
        send(32'hF1, 4'd1, 1'b1, 1);
        clr = 1'b0;
        check("t5_clr_pkt",  {32'd0, pkt_count}, 64'd0);
        check("t5_clr_drop", {48'd0, drop_count}, 64'd0);

        // 6: reset mid-packet, next beat is a first beat
        send(32'h61, 4'd1, 1'b0, 1);
        send(32'h62, 4'd1, 1'b0, 1);
        check("t6_locked_pre", {63'd0, locked}, 64'd1);
        tvalid = 1'b1; tdest = 4'd1;
        rstn = 1'b0;
        #1;
        check("t6_rst_tready", {63'd0, tready}, 64'd0);
        check("t6_rst_wren",   {62'd0, wren},   64'd0);
        check("t6_rst_locked", {63'd0, locked}, 64'd0);
        tvalid = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        send(32'h63, 4'd0, 1'b1, 0);
        check("t6_pkt0", {48'd0, pc(0)}, 64'd1);
        check("t6_pkt1", {48'd0, pc(1)}, 64'd0);

        @(posedge clk); #1;
        check("sb_drained", exp_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
